// File: rtl/bch_corr_out_stage.sv
// BCH correction output stage: XORs each delayed received chunk with its Chien
// error-location mask, frames the codeword and counts the corrected bits.
module bch_corr_out_stage #(
  parameter int    CH_WIDTH    = 2,
  parameter int    CW_CHUNKS   = 8,
  parameter string OUTTER_NAME = "",
  parameter string MODULE_NAME = "bch_corr_out_stage",
  localparam int   ERR_W       = $clog2(CW_CHUNKS * CH_WIDTH + 1),
  localparam int   CNT_W       = (CW_CHUNKS > 1) ? $clog2(CW_CHUNKS) : 1
) (
  input  logic                clk,
  input  logic                in_ctr_Arstn,
  input  logic                in_ctr_Srst,
  input  logic                in_ctr_start,
  input  logic                in_ctr_en,
  input  logic [CH_WIDTH-1:0] in_data,
  input  logic [CH_WIDTH-1:0] in_err_loc,
  input  logic                in_dec_fail,
  output logic [CH_WIDTH-1:0] out_data,
  output logic                out_vld,
  output logic                out_first,
  output logic                out_last,
  output logic                out_fail,
  output logic [ERR_W-1:0]    out_err_cnt,
  output logic                out_done,
  output logic                out_busy
);

  if (CW_CHUNKS < 2) begin : g_bad_cfg
    $error("%s.%s: CW_CHUNKS must be at least 2", OUTTER_NAME, MODULE_NAME);
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [CH_WIDTH-1:0] data_nxt;
  logic [CH_WIDTH-1:0] mask_eff;
  logic [ERR_W-1:0]    err_nxt;
  logic [ERR_W-1:0]    err_pop;
  logic                vld_nxt, first_nxt, last_nxt, fail_nxt, done_nxt;
  logic                is_last;

  assign is_last  = (cnt == CNT_W'(CW_CHUNKS - 1));
  assign out_busy = (state != IDLE);
  // An uncorrectable codeword is passed through untouched and not counted.
  assign mask_eff = out_fail ? '0 : in_err_loc;

  always_comb begin
    err_pop = '0;
    for (int i = 0; i < CH_WIDTH; i++) begin
      err_pop = err_pop + ERR_W'(mask_eff[i]);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    data_nxt  = out_data;
    vld_nxt   = 1'b0;
    first_nxt = 1'b0;
    last_nxt  = 1'b0;
    fail_nxt  = out_fail;
    err_nxt   = out_err_cnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (in_ctr_start) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          err_nxt   = '0;
          fail_nxt  = in_dec_fail;
        end
      end
      RUN: begin
        if (in_ctr_en) begin
          data_nxt  = in_data ^ mask_eff;
          vld_nxt   = 1'b1;
          first_nxt = (cnt == '0);
          last_nxt  = is_last;
          err_nxt   = out_err_cnt + err_pop;
          if (is_last) begin
            cnt_nxt   = '0;
            state_nxt = DONE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      DONE: begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge in_ctr_Arstn) begin
    if (!in_ctr_Arstn) begin
      state       <= IDLE;
      cnt         <= '0;
      out_data    <= '0;
      out_vld     <= 1'b0;
      out_first   <= 1'b0;
      out_last    <= 1'b0;
      out_fail    <= 1'b0;
      out_err_cnt <= '0;
      out_done    <= 1'b0;
    end else if (in_ctr_Srst) begin
      state       <= IDLE;
      cnt         <= '0;
      out_data    <= '0;
      out_vld     <= 1'b0;
      out_first   <= 1'b0;
      out_last    <= 1'b0;
      out_fail    <= 1'b0;
      out_err_cnt <= '0;
      out_done    <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      out_data    <= data_nxt;
      out_vld     <= vld_nxt;
      out_first   <= first_nxt;
      out_last    <= last_nxt;
      out_fail    <= fail_nxt;
      out_err_cnt <= err_nxt;
      out_done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_bch_corr_out_stage.sv
// Directed bench for bch_corr_out_stage with CH_WIDTH=2, CW_CHUNKS=4.
module tb_bch_corr_out_stage;

  logic       clk = 1'b0;
  logic       arstn, srst, start, en, dec_fail;
  logic [1:0] data, mask;
  logic [1:0] out_data;
  logic       out_vld, out_first, out_last, out_fail, out_done, out_busy;
  logic [3:0] out_err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bch_corr_out_stage #(
    .CH_WIDTH   (2),
    .CW_CHUNKS  (4),
    .OUTTER_NAME("tb_bch_corr_out_stage"),
    .MODULE_NAME("dut")
  ) dut (
    .clk         (clk),
    .in_ctr_Arstn(arstn),
    .in_ctr_Srst (srst),
    .in_ctr_start(start),
    .in_ctr_en   (en),
    .in_data     (data),
    .in_err_loc  (mask),
    .in_dec_fail (dec_fail),
    .out_data    (out_data),
    .out_vld     (out_vld),
    .out_first   (out_first),
    .out_last    (out_last),
    .out_fail    (out_fail),
    .out_err_cnt (out_err_cnt),
    .out_done    (out_done),
    .out_busy    (out_busy)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 ns after the rising edge.
  task automatic applyStimulus(input logic s, input logic e, input logic f,
                               input logic [1:0] d, input logic [1:0] m);
    start    = s;
    en       = e;
    dec_fail = f;
    data     = d;
    mask     = m;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic vld, input logic first,
                             input logic last, input logic [1:0] d);
    check({tag, ".vld"},   8'(out_vld),   8'(vld));
    check({tag, ".first"}, 8'(out_first), 8'(first));
    check({tag, ".last"},  8'(out_last),  8'(last));
    check({tag, ".data"},  8'(out_data),  8'(d));
  endtask

  task automatic checkStatus(input string tag, input logic done, input logic busy,
                             input logic fail, input logic [3:0] cnt);
    check({tag, ".done"}, 8'(out_done),    8'(done));
    check({tag, ".busy"}, 8'(out_busy),    8'(busy));
    check({tag, ".fail"}, 8'(out_fail),    8'(fail));
    check({tag, ".cnt"},  8'(out_err_cnt), 8'(cnt));
  endtask

  initial begin
    // Reset held with random inputs
    arstn = 1'b0;
    srst  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start    = 1'($urandom);
      en       = 1'($urandom);
      dec_fail = 1'($urandom);
      data     = 2'($urandom);
      mask     = 2'($urandom);
      @(posedge clk);
    end
    #1;
    checkOutput("rst", 0, 0, 0, 2'b00);
    checkStatus("rst", 0, 0, 0, 4'd0);
    arstn = 1'b1;
    start = 1'b0; en = 1'b0; dec_fail = 1'b0; data = 2'b00; mask = 2'b00;

    // Clean codeword; en during start must be ignored
    applyStimulus(1, 1, 0, 2'b11, 2'b11);
    checkOutput("cw1.start", 0, 0, 0, 2'b00);
    checkStatus("cw1.start", 0, 1, 0, 4'd0);
    applyStimulus(0, 1, 0, 2'b01, 2'b00); checkOutput("cw1.b1", 1, 1, 0, 2'b01);
    applyStimulus(0, 1, 0, 2'b10, 2'b00); checkOutput("cw1.b2", 1, 0, 0, 2'b10);
    applyStimulus(0, 1, 0, 2'b11, 2'b00); checkOutput("cw1.b3", 1, 0, 0, 2'b11);
    applyStimulus(0, 1, 0, 2'b00, 2'b00); checkOutput("cw1.b4", 1, 0, 1, 2'b00);
    checkStatus("cw1.b4", 0, 1, 0, 4'd0);
    applyStimulus(0, 0, 0, 2'b00, 2'b00); checkOutput("cw1.done", 0, 0, 0, 2'b00);
    checkStatus("cw1.done", 1, 0, 0, 4'd0);

    // Corrections, started back-to-back
    applyStimulus(1, 0, 0, 2'b00, 2'b00); checkStatus("cw2.start", 0, 1, 0, 4'd0);
    applyStimulus(0, 1, 0, 2'b01, 2'b01); checkOutput("cw2.b1", 1, 1, 0, 2'b00);
    checkStatus("cw2.b1", 0, 1, 0, 4'd1);
    applyStimulus(0, 1, 0, 2'b10, 2'b00); checkOutput("cw2.b2", 1, 0, 0, 2'b10);
    applyStimulus(0, 1, 0, 2'b11, 2'b11); checkOutput("cw2.b3", 1, 0, 0, 2'b00);
    applyStimulus(0, 1, 0, 2'b00, 2'b00); checkOutput("cw2.b4", 1, 0, 1, 2'b00);
    applyStimulus(0, 0, 0, 2'b00, 2'b00); checkStatus("cw2.done", 1, 0, 0, 4'd3);

    // Stall of 3 cycles between chunks 2 and 3
    applyStimulus(1, 0, 0, 2'b00, 2'b00); checkStatus("cw3.start", 0, 1, 0, 4'd0);
    applyStimulus(0, 1, 0, 2'b01, 2'b01); checkOutput("cw3.b1", 1, 1, 0, 2'b00);
    applyStimulus(0, 1, 0, 2'b10, 2'b00); checkOutput("cw3.b2", 1, 0, 0, 2'b10);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 2'b11, 2'b11);
      checkOutput($sformatf("cw3.stall%0d", i), 0, 0, 0, 2'b10);
      checkStatus($sformatf("cw3.stall%0d", i), 0, 1, 0, 4'd1);
    end
    applyStimulus(0, 1, 0, 2'b11, 2'b11); checkOutput("cw3.b3", 1, 0, 0, 2'b00);
    applyStimulus(0, 1, 0, 2'b00, 2'b00); checkOutput("cw3.b4", 1, 0, 1, 2'b00);
    applyStimulus(0, 0, 0, 2'b00, 2'b00); checkStatus("cw3.done", 1, 0, 0, 4'd3);

    // Uncorrectable codeword passes data through uncounted
    applyStimulus(1, 0, 1, 2'b00, 2'b00); checkStatus("cw4.start", 0, 1, 1, 4'd0);
    applyStimulus(0, 1, 0, 2'b01, 2'b11); checkOutput("cw4.b1", 1, 1, 0, 2'b01);
    applyStimulus(0, 1, 0, 2'b10, 2'b11); checkOutput("cw4.b2", 1, 0, 0, 2'b10);
    applyStimulus(0, 1, 0, 2'b11, 2'b11); checkOutput("cw4.b3", 1, 0, 0, 2'b11);
    applyStimulus(0, 1, 0, 2'b00, 2'b11); checkOutput("cw4.b4", 1, 0, 1, 2'b00);
    applyStimulus(0, 0, 0, 2'b00, 2'b00); checkStatus("cw4.done", 1, 0, 1, 4'd0);

    // Start while running is ignored
    applyStimulus(1, 0, 0, 2'b00, 2'b00); checkStatus("cw5.start", 0, 1, 0, 4'd0);
    applyStimulus(0, 1, 0, 2'b01, 2'b00); checkOutput("cw5.b1", 1, 1, 0, 2'b01);
    applyStimulus(0, 1, 0, 2'b10, 2'b00); checkOutput("cw5.b2", 1, 0, 0, 2'b10);
    applyStimulus(1, 1, 1, 2'b11, 2'b01); checkOutput("cw5.b3", 1, 0, 0, 2'b10);
    checkStatus("cw5.b3", 0, 1, 0, 4'd1);
    applyStimulus(0, 1, 0, 2'b00, 2'b00); checkOutput("cw5.b4", 1, 0, 1, 2'b00);
    applyStimulus(0, 0, 0, 2'b00, 2'b00); checkStatus("cw5.done", 1, 0, 0, 4'd1);

    // Asynchronous reset mid-codeword, then a normal codeword
    applyStimulus(1, 0, 0, 2'b00, 2'b00);
    applyStimulus(0, 1, 0, 2'b11, 2'b01); checkOutput("arst.b1", 1, 1, 0, 2'b10);
    applyStimulus(0, 1, 0, 2'b11, 2'b10); checkStatus("arst.b2", 0, 1, 0, 4'd2);
    #2;
    arstn = 1'b0;
    #1;
    checkOutput("arst.now", 0, 0, 0, 2'b00);
    checkStatus("arst.now", 0, 0, 0, 4'd0);
    @(posedge clk);
    #1;
    arstn = 1'b1;
    applyStimulus(1, 0, 0, 2'b00, 2'b00); checkStatus("cw6.start", 0, 1, 0, 4'd0);
    applyStimulus(0, 1, 0, 2'b11, 2'b10); checkOutput("cw6.b1", 1, 1, 0, 2'b01);
    applyStimulus(0, 1, 0, 2'b11, 2'b00); checkOutput("cw6.b2", 1, 0, 0, 2'b11);
    applyStimulus(0, 1, 0, 2'b11, 2'b00); checkOutput("cw6.b3", 1, 0, 0, 2'b11);
    applyStimulus(0, 1, 0, 2'b11, 2'b00); checkOutput("cw6.b4", 1, 0, 1, 2'b11);
    applyStimulus(0, 0, 0, 2'b00, 2'b00); checkStatus("cw6.done", 1, 0, 0, 4'd1);

    // Synchronous clear mid-codeword beats simultaneous start/en
    applyStimulus(1, 0, 0, 2'b00, 2'b00);
    applyStimulus(0, 1, 0, 2'b01, 2'b01); checkOutput("srst.b1", 1, 1, 0, 2'b00);
    applyStimulus(0, 1, 0, 2'b10, 2'b10); checkStatus("srst.b2", 0, 1, 0, 4'd2);
    srst = 1'b1;
    applyStimulus(1, 1, 1, 2'b11, 2'b11);
    checkOutput("srst.now", 0, 0, 0, 2'b00);
    checkStatus("srst.now", 0, 0, 0, 4'd0);
    srst = 1'b0;
    applyStimulus(1, 0, 0, 2'b00, 2'b00); checkStatus("cw7.start", 0, 1, 0, 4'd0);
    applyStimulus(0, 1, 0, 2'b10, 2'b00); checkOutput("cw7.b1", 1, 1, 0, 2'b10);
    applyStimulus(0, 1, 0, 2'b01, 2'b11); checkOutput("cw7.b2", 1, 0, 0, 2'b10);
    applyStimulus(0, 1, 0, 2'b00, 2'b00); checkOutput("cw7.b3", 1, 0, 0, 2'b00);
    applyStimulus(0, 1, 0, 2'b00, 2'b01); checkOutput("cw7.b4", 1, 0, 1, 2'b01);
    applyStimulus(0, 0, 0, 2'b00, 2'b00); checkStatus("cw7.done", 1, 0, 0, 4'd3);
    applyStimulus(0, 0, 0, 2'b00, 2'b00); checkStatus("cw7.after", 0, 0, 0, 4'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
